// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch constants and FSM state encodings.
package fetch_ctrl_pkg;
   localparam logic [31:0] PC_INIT  = 32'h0000_3000;
   localparam int          IM_WORDS = 4096;
   localparam int          QDEPTH   = 2;
   localparam logic [31:0] IM_BYTES = 32'(4 * IM_WORDS);
   typedef enum logic {FETCH_RUN = 1'b0, FETCH_HALT = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: parameterised FIFO with same-cycle push/pop and a flush that wins over both.
module fetch_fifo #(
   parameter int W = 65,
   parameter int D = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(D);
   logic [W-1:0] mem_q [D];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0] cnt_q;
   logic do_push, do_pop;
   assign full_o  = cnt_q == (AW+1)'(D);
   assign empty_o = cnt_q == '0;
   // a push into a full queue is only legal when the head leaves this cycle
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_q];
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_q + AW'(do_pop);
         wr_q  <= wr_q + AW'(do_push);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
   end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer feeding a fetch FIFO toward decode, with redirect support.
// Define FETCH_RANGE_CHECK_EN to enable address checking, fault markers and HALT.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] im_pc,
   input  logic [31:0] im_instr,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic        f_valid,
   input  logic        f_ready,
   output logic [31:0] f_instr,
   output logic [31:0] f_pc,
   output logic        f_fault
);
   fetch_state_e state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic full, empty, pop, fetch, fault;
   logic [64:0] head, wdata;
`ifdef FETCH_RANGE_CHECK_EN
   assign fault = (pc_q[1:0] != 2'b00) || ((pc_q - PC_INIT) >= IM_BYTES);
`else
   assign fault = 1'b0;
`endif
   assign im_pc = pc_q;
   assign f_valid = ~empty;
   assign pop = f_valid & f_ready;
   assign fetch = (state_q == FETCH_RUN) && (!full || pop);
   assign wdata = {fault, pc_q, fault ? 32'h0 : im_instr};
   assign {f_fault, f_pc, f_instr} = f_valid ? head : 65'h0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH_RUN;
         pc_q    <= PC_INIT;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end
   // redirect outranks fetch, fault and HALT; a faulting fetch parks the PC
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      state_d = redirect_en ? FETCH_RUN : (fetch && fault) ? FETCH_HALT : state_q;
      pc_d    = redirect_en ? redirect_pc : (fetch && !fault) ? pc_q + 32'd4 : pc_q;
   end
   fetch_fifo #(.W(65), .D(QDEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (fetch & ~redirect_en),
      .pop_i   (pop),
      .flush_i (redirect_en),
      .wdata_i (wdata),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for fetch_ctrl; fault expectations follow FETCH_RANGE_CHECK_EN.
module tb_fetch_ctrl;
   logic clk = 1'b0, reset = 1'b0, redirect_en = 1'b0, f_ready = 1'b0;
   logic [31:0] im_pc, im_instr, redirect_pc = 32'h0, f_instr, f_pc;
   logic f_valid, f_fault;
   int nvec = 0, nerr = 0;
   always #5 clk = ~clk;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h3000: return 32'h11;
         32'h3004: return 32'h22;
         32'h3008: return 32'h33;
         default:  return a ^ 32'h5A5A_0000;
      endcase
   endfunction
   assign im_instr = mem_word(im_pc);
   fetch_ctrl dut (
      .clk(clk), .reset(reset), .im_pc(im_pc), .im_instr(im_instr),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .f_valid(f_valid),
      .f_ready(f_ready), .f_instr(f_instr), .f_pc(f_pc), .f_fault(f_fault)
   );
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      f_ready = 1'b0;
      redirect_en = 1'b0;
      tick();
      reset = 1'b0;
   endtask
   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      nvec++;
      if ({f_valid, f_fault, f_pc, f_instr} !== 66'h0) begin
         nerr++;
         $display("FAIL reset_head got v=%b f=%b pc=%h i=%h want all zero", f_valid, f_fault, f_pc, f_instr);
      end
      nvec++;
      if (im_pc !== 32'h3000) begin nerr++; $display("FAIL reset_im_pc got %h want 00003000", im_pc); end
      do_reset();
   endtask
   task automatic test_stream();
      logic [31:0] pcs [3];
      pcs = '{32'h3000, 32'h3004, 32'h3008};
      do_reset();
      f_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if ({f_valid, f_fault, f_pc, f_instr} !== {2'b10, pcs[i], mem_word(pcs[i])}) begin
            nerr++;
            $display("FAIL stream_%0d got v=%b f=%b pc=%h i=%h want pc=%h i=%h", i, f_valid, f_fault, f_pc, f_instr, pcs[i], mem_word(pcs[i]));
         end
         nvec++;
         if (im_pc !== pcs[i] + 32'd4) begin nerr++; $display("FAIL stream_im_pc_%0d got %h want %h", i, im_pc, pcs[i] + 32'd4); end
      end
   endtask
   task automatic test_stall();
      do_reset();
      repeat (5) tick();
      nvec++;
      if (im_pc !== 32'h3008) begin nerr++; $display("FAIL stall_im_pc got %h want 00003008", im_pc); end
      nvec++;
      if ({f_valid, f_pc} !== {1'b1, 32'h3000}) begin nerr++; $display("FAIL stall_head got v=%b pc=%h want 1/00003000", f_valid, f_pc); end
      f_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         nvec++;
         if ({f_valid, f_fault, f_pc, f_instr} !== {2'b10, 32'h3004 + 32'(4 * i), mem_word(32'h3004 + 32'(4 * i))}) begin
            nerr++;
            $display("FAIL drain_%0d got v=%b pc=%h i=%h want pc=%h", i, f_valid, f_pc, f_instr, 32'h3004 + 32'(4 * i));
         end
      end
   endtask
   task automatic test_redirect();
      do_reset();
      tick();
      tick();
      f_ready = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 32'h3100;
      #1;
      nvec++;
      if ({f_valid, f_pc} !== {1'b1, 32'h3000}) begin nerr++; $display("FAIL redir_pop got v=%b pc=%h want 1/00003000", f_valid, f_pc); end
      tick();
      redirect_en = 1'b0;
      nvec++;
      if ({f_valid, f_pc, im_pc} !== {1'b0, 32'h0, 32'h3100}) begin
         nerr++;
         $display("FAIL redir_flush got v=%b pc=%h im_pc=%h want 0/0/00003100", f_valid, f_pc, im_pc);
      end
      tick();
      nvec++;
      if ({f_valid, f_fault, f_pc, f_instr} !== {2'b10, 32'h3100, mem_word(32'h3100)}) begin
         nerr++;
         $display("FAIL redir_target got v=%b pc=%h i=%h want pc=00003100", f_valid, f_pc, f_instr);
      end
   endtask
   task automatic test_misaligned();
      redirect_en = 1'b1;
      redirect_pc = 32'h3002;
      tick();
      redirect_en = 1'b0;
      tick();
`ifdef FETCH_RANGE_CHECK_EN
      nvec++;
      if ({f_valid, f_fault, f_pc, f_instr} !== {2'b11, 32'h3002, 32'h0}) begin
         nerr++;
         $display("FAIL misalign_marker got v=%b f=%b pc=%h i=%h want 1/1/00003002/0", f_valid, f_fault, f_pc, f_instr);
      end
      repeat (2) tick();
      nvec++;
      if ({f_valid, im_pc} !== {1'b0, 32'h3002}) begin nerr++; $display("FAIL halt_idle got v=%b im_pc=%h want 0/00003002", f_valid, im_pc); end
`else
      nvec++;
      if ({f_valid, f_fault, f_pc, f_instr} !== {2'b10, 32'h3002, mem_word(32'h3002)}) begin
         nerr++;
         $display("FAIL misalign_normal got v=%b f=%b pc=%h i=%h want pc=00003002", f_valid, f_fault, f_pc, f_instr);
      end
      tick();
      nvec++;
      if ({f_valid, f_pc} !== {1'b1, 32'h3006}) begin nerr++; $display("FAIL misalign_next got v=%b pc=%h want 1/00003006", f_valid, f_pc); end
`endif
      redirect_en = 1'b1;
      redirect_pc = 32'h3000;
      tick();
      redirect_en = 1'b0;
      tick();
      nvec++;
      if ({f_valid, f_fault, f_pc, f_instr} !== {2'b10, 32'h3000, 32'h11}) begin
         nerr++;
         $display("FAIL resume got v=%b f=%b pc=%h i=%h want 1/0/00003000/00000011", f_valid, f_fault, f_pc, f_instr);
      end
   endtask
   task automatic test_range_end();
      redirect_en = 1'b1;
      redirect_pc = 32'h6FFC;
      tick();
      redirect_en = 1'b0;
      tick();
      nvec++;
      if ({f_valid, f_fault, f_pc} !== {2'b10, 32'h6FFC}) begin nerr++; $display("FAIL last_word got v=%b f=%b pc=%h want 1/0/00006ffc", f_valid, f_fault, f_pc); end
      tick();
`ifdef FETCH_RANGE_CHECK_EN
      nvec++;
      if ({f_valid, f_fault, f_pc, f_instr, im_pc} !== {2'b11, 32'h7000, 32'h0, 32'h7000}) begin
         nerr++;
         $display("FAIL range_marker got v=%b f=%b pc=%h i=%h im_pc=%h want fault at 00007000", f_valid, f_fault, f_pc, f_instr, im_pc);
      end
`else
      nvec++;
      if ({f_valid, f_fault, f_pc, f_instr, im_pc} !== {2'b10, 32'h7000, mem_word(32'h7000), 32'h7004}) begin
         nerr++;
         $display("FAIL range_normal got v=%b f=%b pc=%h i=%h im_pc=%h want normal 00007000", f_valid, f_fault, f_pc, f_instr, im_pc);
      end
`endif
   endtask
   task automatic test_async_reset();
      do_reset();
      tick();
      #2;
      reset = 1'b1;
      #1;
      nvec++;
      if ({f_valid, im_pc} !== {1'b0, 32'h3000}) begin nerr++; $display("FAIL async_reset got v=%b im_pc=%h want 0/00003000", f_valid, im_pc); end
      @(negedge clk);
      reset = 1'b0;
      nvec++;
      if ({f_valid, im_pc} !== {1'b0, 32'h3000}) begin nerr++; $display("FAIL post_reset got v=%b im_pc=%h want 0/00003000", f_valid, im_pc); end
   endtask
   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_misaligned();
      test_range_end();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
